// File: rtl/rocc_pkg.sv
// rocc_pkg: shared widths and record types for the RoCC response tracker.
//   ROCC_RD_BITS        destination register index width
//   ROCC_TRANS_ID_BITS  scoreboard transaction id width (matches tracker default)
//   ROCC_XLEN           response data width (matches tracker default)
//   rocc_tag_t          per-command record kept while a response is owed
//   rocc_wb_t           buffered result presented to writeback
package rocc_pkg;
    localparam int ROCC_RD_BITS       = 5;
    localparam int ROCC_TRANS_ID_BITS = 3;
    localparam int ROCC_XLEN          = 64;

    typedef struct packed {
        logic [ROCC_TRANS_ID_BITS-1:0] trans_id;
        logic [ROCC_RD_BITS-1:0]       rd;
    } rocc_tag_t;

    typedef struct packed {
        logic [ROCC_TRANS_ID_BITS-1:0] trans_id;
        logic [ROCC_XLEN-1:0]          result;
        logic                          ex_valid;
    } rocc_wb_t;
endpackage

// File: rtl/rocc_tag_fifo.sv
// rocc_tag_fifo: in-order tag FIFO, DEPTH entries of type T.
//   push_i/data_i  write an entry (ignored when full or flushing)
//   pop_i/data_o   data_o shows the head; pop_i retires it (ignored when empty)
//   flush_i        discards all entries
//   count_o        occupancy 0..DEPTH; full_o/empty_o decoded from it
module rocc_tag_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output T                           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign full_o  = r_count == CW'(DEPTH);
    assign empty_o = r_count == '0;
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o & ~flush_i;
    assign w_pop   = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end
endmodule

// File: rtl/rocc_resp_tracker.sv
// rocc_resp_tracker: pairs in-order RoCC responses with their command tags for writeback.
//   Command side : cmd_fire_i/cmd_xd_i/cmd_trans_id_i/cmd_rd_i record a tag; tag_full_o blocks issue.
//   Response side: resp_valid_i/resp_ready_o/resp_data_i/resp_rd_i.
//   Writeback    : wb_valid_o/wb_ready_i/wb_trans_id_o/wb_result_o/wb_ex_valid_o (1-entry buffer).
//   flush_i squashes responses owed to flushed commands; orphan_err_o is sticky until rst_i.
//   Option macro ROCC_RESP_RD_CHECK_EN: store rd and flag an rd mismatch via wb_ex_valid_o.
module rocc_resp_tracker
    import rocc_pkg::*;
#(
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 4,
    parameter int XLEN          = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     cmd_fire_i,
    input  logic                     cmd_xd_i,
    input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
    input  logic [ROCC_RD_BITS-1:0]  cmd_rd_i,
    output logic                     tag_full_o,
    input  logic                     resp_valid_i,
    output logic                     resp_ready_o,
    input  logic [XLEN-1:0]          resp_data_i,
    input  logic [ROCC_RD_BITS-1:0]  resp_rd_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic                     wb_ex_valid_o,
    output logic                     orphan_err_o
);
    localparam int CW = $clog2(DEPTH + 1);

    rocc_tag_t     w_push_tag, w_head;
    rocc_wb_t      r_wb;
    logic          r_wb_valid, r_orphan;
    logic [CW-1:0] r_drop, w_count;
    logic          w_push, w_acc, w_drop, w_pop, w_orphan, w_ex, w_fifo_full, w_fifo_empty;

    // drop_q slots are still owed a response, so they occupy capacity too
    assign tag_full_o   = ({1'b0, w_count} + {1'b0, r_drop}) == (CW+1)'(DEPTH);
    assign resp_ready_o = ~r_wb_valid | wb_ready_i;
    assign w_push       = cmd_fire_i & cmd_xd_i & ~flush_i;
    assign w_acc        = resp_valid_i & resp_ready_o;
    assign w_drop       = w_acc & (r_drop != '0);
    assign w_pop        = w_acc & (r_drop == '0) & (w_count != '0);
    assign w_orphan     = w_acc & (r_drop == '0) & (w_count == '0);

`ifdef ROCC_RESP_RD_CHECK_EN
    assign w_push_tag = '{trans_id: cmd_trans_id_i, rd: cmd_rd_i};
    assign w_ex       = resp_rd_i != w_head.rd;
`else
    logic w_unused_rd;
    assign w_push_tag  = '{trans_id: cmd_trans_id_i, rd: '0};
    assign w_ex        = 1'b0;
    assign w_unused_rd = ^{cmd_rd_i, resp_rd_i, w_head.rd};
`endif

    rocc_tag_fifo #(.DEPTH(DEPTH), .T(rocc_tag_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push & ~tag_full_o),
        .data_i  (w_push_tag),
        .pop_i   (w_pop),
        .flush_i (flush_i),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // every entry emptied by a flush still owes a response that must be squashed
    always_ff @(posedge clk_i) begin
        if (rst_i)        r_drop <= '0;
        else if (flush_i) r_drop <= r_drop + w_count - CW'(w_drop) - CW'(w_pop);
        else if (w_drop)  r_drop <= r_drop - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (flush_i)         r_wb_valid <= 1'b0;
            else if (w_pop)      r_wb_valid <= 1'b1;
            else if (wb_ready_i) r_wb_valid <= 1'b0;
            if (w_pop && !flush_i) r_wb <= '{trans_id: w_head.trans_id, result: resp_data_i, ex_valid: w_ex};
            if (w_orphan) r_orphan <= 1'b1;
        end
    end

    assign wb_valid_o    = r_wb_valid;
    assign wb_trans_id_o = r_wb.trans_id;
    assign wb_result_o   = r_wb.result;
    assign wb_ex_valid_o = r_wb.ex_valid;
    assign orphan_err_o  = r_orphan;

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && tag_full_o));
endmodule

// File: tb/tb_rocc_resp_tracker.sv
// tb_rocc_resp_tracker: table-driven directed bench for rocc_resp_tracker.
module tb_rocc_resp_tracker;
    import rocc_pkg::*;
`ifdef ROCC_RESP_RD_CHECK_EN
    localparam bit RDC = 1'b1;
`else
    localparam bit RDC = 1'b0;
`endif

    logic        clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
    logic        cmd_fire_i = 1'b0, cmd_xd_i = 1'b0;
    logic [2:0]  cmd_trans_id_i = '0;
    logic [4:0]  cmd_rd_i = '0, resp_rd_i = '0;
    logic        resp_valid_i = 1'b0, wb_ready_i = 1'b1;
    logic [63:0] resp_data_i = '0;
    logic        tag_full_o, resp_ready_o, wb_valid_o, wb_ex_valid_o, orphan_err_o;
    logic [2:0]  wb_trans_id_o;
    logic [63:0] wb_result_o;

    always #5 clk_i = ~clk_i;

    rocc_resp_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .cmd_fire_i(cmd_fire_i), .cmd_xd_i(cmd_xd_i), .cmd_trans_id_i(cmd_trans_id_i), .cmd_rd_i(cmd_rd_i),
        .tag_full_o(tag_full_o), .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_data_i(resp_data_i), .resp_rd_i(resp_rd_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o), .wb_ex_valid_o(wb_ex_valid_o),
        .orphan_err_o(orphan_err_o)
    );

    typedef struct {
        logic        fl, fi, xd;
        logic [2:0]  tid;
        logic [4:0]  rd;
        logic        rv;
        logic [63:0] rdata;
        logic [4:0]  rrd;
        logic        wbr;
        logic        e_full, e_rr, e_v;
        logic [2:0]  e_tid;
        logic [63:0] e_res;
        logic        e_ex, e_or;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0, n_pass = 0;

    function automatic vec_t mk(logic fl, logic fi, logic xd, logic [2:0] tid, logic [4:0] rd,
                                logic rv, logic [63:0] rdata, logic [4:0] rrd, logic wbr,
                                logic e_full, logic e_rr, logic e_v, logic [2:0] e_tid,
                                logic [63:0] e_res, logic e_ex, logic e_or);
        vec_t v;
        v.fl = fl; v.fi = fi; v.xd = xd; v.tid = tid; v.rd = rd; v.rv = rv; v.rdata = rdata;
        v.rrd = rrd; v.wbr = wbr; v.e_full = e_full; v.e_rr = e_rr; v.e_v = e_v; v.e_tid = e_tid;
        v.e_res = e_res; v.e_ex = e_ex; v.e_or = e_or;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(logic fl, logic fi, logic xd, logic [2:0] tid, logic [4:0] rd,
                         logic rv, logic [63:0] rdata, logic [4:0] rrd, logic wbr);
        flush_i = fl; cmd_fire_i = fi; cmd_xd_i = xd; cmd_trans_id_i = tid; cmd_rd_i = rd;
        resp_valid_i = rv; resp_data_i = rdata; resp_rd_i = rrd; wb_ready_i = wbr;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
    endtask

    initial begin
        // fl fi xd tid rd  rv data rrd wbr | full rr v tid res ex or
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,0));        // reset state
        vq.push_back(mk(0,1,1,3,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,5,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'hA,0,1,      0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'hB,0,1,      0,1,1,3,'hA,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,5,'hB,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,1,0, 0,0,0,1,        0,1,0,0,0,0,0));        // fill to DEPTH
        vq.push_back(mk(0,1,0,7,0, 0,0,0,1,        0,1,0,0,0,0,0));        // xd=0 never pushes
        vq.push_back(mk(0,1,1,2,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,3,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,4,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        1,1,0,0,0,0,0));
        vq.push_back(mk(0,1,0,7,0, 0,0,0,1,        1,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'h11,0,1,     1,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,1,'h11,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'h22,0,0,     0,1,0,0,0,0,0));        // backpressure
        vq.push_back(mk(0,0,0,0,0, 1,'h33,0,0,     0,0,1,2,'h22,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'h33,0,0,     0,0,1,2,'h22,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'h33,0,1,     0,1,1,2,'h22,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,3,'h33,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,5,0, 0,0,0,1,        0,1,0,0,0,0,0));        // two outstanding
        vq.push_back(mk(1,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,0));        // flush
        vq.push_back(mk(0,0,0,0,0, 1,'h44,0,1,     0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'h55,0,1,     0,1,0,0,0,0,0));
        vq.push_back(mk(0,1,1,6,0, 0,0,0,1,        0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 1,'hC,0,1,      0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,6,'hC,0,0));
        vq.push_back(mk(1,1,1,7,0, 0,0,0,1,        0,1,0,0,0,0,0));        // cmd in flush cycle ignored
        vq.push_back(mk(0,0,0,0,0, 1,'hD,0,1,      0,1,0,0,0,0,0));        // orphan
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,0,0,0,0,1));
        vq.push_back(mk(0,1,1,2,5, 0,0,0,1,        0,1,0,0,0,0,1));        // rd check
        vq.push_back(mk(0,0,0,0,0, 1,'hE,7,1,      0,1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,2,'hE,RDC,1));
        vq.push_back(mk(0,1,1,3,9, 0,0,0,1,        0,1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0, 1,'hF,9,1,      0,1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,1,        0,1,1,3,'hF,0,1));

        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            if (i > 0) @(negedge clk_i);
            drive(vq[i].fl, vq[i].fi, vq[i].xd, vq[i].tid, vq[i].rd, vq[i].rv, vq[i].rdata, vq[i].rrd, vq[i].wbr);
            #1;
            chk("tag_full", i, 64'(tag_full_o), 64'(vq[i].e_full));
            chk("resp_ready", i, 64'(resp_ready_o), 64'(vq[i].e_rr));
            chk("wb_valid", i, 64'(wb_valid_o), 64'(vq[i].e_v));
            chk("orphan_err", i, 64'(orphan_err_o), 64'(vq[i].e_or));
            if (vq[i].e_v) begin
                chk("wb_trans_id", i, 64'(wb_trans_id_o), 64'(vq[i].e_tid));
                chk("wb_result", i, wb_result_o, vq[i].e_res);
                chk("wb_ex_valid", i, 64'(wb_ex_valid_o), 64'(vq[i].e_ex));
            end
        end

        // flushed-but-unanswered entries keep tag_full asserted until answered
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive(0, 1, 1, 3'(k), 0, 0, 0, 0, 1);
        end
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("full_before_flush", 100, 64'(tag_full_o), 64'd1);
        idle_cycle();
        chk("full_drops_only", 101, 64'(tag_full_o), 64'd1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 1, 64'h99, 0, 1);
        #1;
        chk("drop_resp_ready", 102, 64'(resp_ready_o), 64'd1);
        idle_cycle();
        chk("full_after_drop", 103, 64'(tag_full_o), 64'd0);
        chk("dropped_no_wb", 103, 64'(wb_valid_o), 64'd0);

        // reset mid-operation: remaining owed responses become orphans
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_orphan", 104, 64'(orphan_err_o), 64'd0);
        chk("rst_full", 104, 64'(tag_full_o), 64'd0);
        chk("rst_wb_valid", 104, 64'(wb_valid_o), 64'd0);
        chk("rst_resp_ready", 104, 64'(resp_ready_o), 64'd1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 1, 64'h77, 0, 1);
        idle_cycle();
        chk("post_rst_orphan", 105, 64'(orphan_err_o), 64'd1);
        chk("post_rst_no_wb", 105, 64'(wb_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
